// File: rtl/ddr3_app_pkg.sv
// Shared command codes, sequencer state encoding and width helper for the DDR3 app-side sequencer.
// No logic; compile before the modules that import it.
// Not applicable: holds no flow-controlled path.
package ddr3_app_pkg;
    localparam logic [2:0] APP_CMD_WR = 3'd0;
    localparam logic [2:0] APP_CMD_RD = 3'd1;

    typedef enum logic [1:0] {
        IDLE,
        WR_CMD,
        WR_DATA,
        RD_CMD
    } seq_state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction
endpackage

// File: rtl/rd_len_queue.sv
// Small synchronous FIFO holding the burst length (beats-1) of every read still awaiting data.
// Head is valid in the cycle after a push into an empty queue.
// Push is ignored when full and pop when empty; the owner gates both.
module rd_len_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    import ddr3_app_pkg::*;

    localparam int PTR_W = clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; occupancy alone defines what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_dat;
    end
endmodule

// File: rtl/ddr3_app_sequencer.sv
// Sequences CDC-FIFO commands onto the DDR3 app interface: write bursts, credit-checked reads, last-beat tagging.
// Command strobe one cycle after acceptance (reads wait for credit); write beats combinational; read beats 1 cycle.
// Holds commands while app_cmd_ready is low, passes app_wdata_ready back to wd_ready, read return has no backpressure.
module ddr3_app_sequencer #(
    parameter int ADDR_WIDTH    = 27,
    parameter int BRST_WIDTH    = 6,
    parameter int DATA_WIDTH    = 128,
    parameter int MASK_WIDTH    = DATA_WIDTH/8,
    parameter int RSP_CNT_WIDTH = 8,
    parameter int RD_OUTS_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_write,
    input  logic [ADDR_WIDTH-1:0]    cmd_addr,
    input  logic [BRST_WIDTH-1:0]    cmd_len,
    input  logic                     wd_valid,
    output logic                     wd_ready,
    input  logic [DATA_WIDTH-1:0]    wd_data,
    input  logic [MASK_WIDTH-1:0]    wd_mask,
    input  logic [RSP_CNT_WIDTH-1:0] rsp_free,
    output logic                     rd_valid,
    output logic [DATA_WIDTH-1:0]    rd_data,
    output logic                     rd_last,
    input  logic                     app_init_calib_complete,
    input  logic                     app_cmd_ready,
    output logic [2:0]               app_cmd,
    output logic                     app_cmd_en,
    output logic [ADDR_WIDTH-1:0]    app_addr,
    output logic [BRST_WIDTH-1:0]    app_burst_number,
    input  logic                     app_wdata_ready,
    output logic                     app_wdata_en,
    output logic                     app_wdata_end,
    output logic [DATA_WIDTH-1:0]    app_wdata,
    output logic [MASK_WIDTH-1:0]    app_wdata_mask,
    input  logic                     app_rdata_valid,
    input  logic                     app_rdata_end,
    input  logic [DATA_WIDTH-1:0]    app_rdata,
    output logic                     busy,
    output logic                     err_rd_unexp
);
    import ddr3_app_pkg::*;

    localparam int SUM_W = RSP_CNT_WIDTH + 1;

    seq_state_t            state;
    logic                  calib_q;
    logic [BRST_WIDTH-1:0] lat_len;
    logic [BRST_WIDTH-1:0] beat_cnt;
    logic [BRST_WIDTH-1:0] rd_beat;
    logic [BRST_WIDTH-1:0] q_head;
    logic [SUM_W-1:0]      outs_beats;
    logic [SUM_W-1:0]      len_beats;
    logic [SUM_W-1:0]      need_beats;
    logic                  q_full;
    logic                  q_empty;
    logic                  q_push;
    logic                  q_pop;
    logic                  cmd_fire;
    logic                  wr_fire;
    logic                  rd_cmd_fire;
    logic                  rd_beat_vld;
    logic                  credit_ok;
    logic                  unused_rdata_end;

    assign unused_rdata_end = app_rdata_end;

    // calib_q keeps cmd_ready low while reset is asserted even if calibration is already reported.
    assign cmd_ready   = (state == IDLE) && app_init_calib_complete && calib_q;
    assign cmd_fire    = cmd_valid && cmd_ready;
    assign wr_fire     = (state == WR_DATA) && wd_valid && app_wdata_ready;
    assign rd_cmd_fire = (state == RD_CMD) && app_cmd_en && app_cmd_ready;
    assign len_beats   = SUM_W'(lat_len) + SUM_W'(1);
    assign need_beats  = len_beats + outs_beats;
    assign credit_ok   = ({1'b0, rsp_free} >= need_beats) && !q_full;
    assign rd_beat_vld = app_rdata_valid && !q_empty;
    assign q_push      = rd_cmd_fire;
    assign q_pop       = rd_beat_vld && (rd_beat == q_head);
    assign busy        = (state != IDLE) || !q_empty;

    always_comb begin
        wd_ready       = 1'b0;
        app_wdata_en   = 1'b0;
        app_wdata_end  = 1'b0;
        app_wdata      = '0;
        app_wdata_mask = '1;
        if (state == WR_DATA) begin
            wd_ready       = app_wdata_ready;
            app_wdata_en   = wd_valid;
            app_wdata_end  = wd_valid;
            app_wdata      = wd_data;
            app_wdata_mask = wd_mask;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state            <= IDLE;
            calib_q          <= 1'b0;
            lat_len          <= '0;
            beat_cnt         <= '0;
            app_cmd          <= '0;
            app_cmd_en       <= 1'b0;
            app_addr         <= '0;
            app_burst_number <= '0;
        end else begin
            calib_q <= app_init_calib_complete;
            case (state)
                IDLE: begin
                    if (cmd_fire) begin
                        lat_len          <= cmd_len;
                        app_addr         <= cmd_addr;
                        app_burst_number <= cmd_len;
                        if (cmd_write) begin
                            app_cmd    <= APP_CMD_WR;
                            app_cmd_en <= 1'b1;
                            state      <= WR_CMD;
                        end else begin
                            app_cmd <= APP_CMD_RD;
                            state   <= RD_CMD;
                        end
                    end
                end
                WR_CMD: begin
                    if (app_cmd_ready) begin
                        app_cmd_en <= 1'b0;
                        beat_cnt   <= '0;
                        state      <= WR_DATA;
                    end
                end
                WR_DATA: begin
                    if (wr_fire) begin
                        if (beat_cnt == lat_len) state <= IDLE;
                        else                     beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                RD_CMD: begin
                    // Credit is re-evaluated every cycle until the controller takes the command.
                    if (rd_cmd_fire) begin
                        app_cmd_en <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        app_cmd_en <= credit_ok;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_valid     <= 1'b0;
            rd_data      <= '0;
            rd_last      <= 1'b0;
            rd_beat      <= '0;
            outs_beats   <= '0;
            err_rd_unexp <= 1'b0;
        end else begin
            rd_valid <= app_rdata_valid;
            rd_data  <= app_rdata;
            rd_last  <= q_pop;
            if (q_pop)            rd_beat <= '0;
            else if (rd_beat_vld) rd_beat <= rd_beat + 1'b1;
            if (app_rdata_valid && q_empty) err_rd_unexp <= 1'b1;
            outs_beats <= outs_beats + (q_push ? len_beats : SUM_W'(0))
                                     - (rd_beat_vld ? SUM_W'(1) : SUM_W'(0));
        end
    end

    rd_len_queue #(
        .DEPTH (RD_OUTS_DEPTH),
        .WIDTH (BRST_WIDTH)
    ) u_rd_len_queue (
        .clk      (clk),
        .rstn     (rstn),
        .push     (q_push),
        .push_dat (lat_len),
        .pop      (q_pop),
        .head     (q_head),
        .full     (q_full),
        .empty    (q_empty)
    );
endmodule

// File: tb/tb_ddr3_app_sequencer.sv
// Directed bench for ddr3_app_sequencer: write bursts, credit-gated reads, outstanding limit, error flag, reset.
module tb_ddr3_app_sequencer;
    localparam int AW = 27;
    localparam int BW = 6;
    localparam int DW = 128;
    localparam int MW = 16;
    localparam int RW = 8;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          cmd_valid = 1'b0, cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [BW-1:0] cmd_len = '0;
    logic          wd_valid = 1'b0;
    logic [DW-1:0] wd_data = '0;
    logic [MW-1:0] wd_mask = '0;
    logic [RW-1:0] rsp_free = 8'd16;
    logic          app_init_calib_complete = 1'b1;
    logic          app_cmd_ready = 1'b1, app_wdata_ready = 1'b1;
    logic          app_rdata_valid = 1'b0, app_rdata_end = 1'b0;
    logic [DW-1:0] app_rdata = '0;
    logic          cmd_ready, wd_ready, rd_valid, rd_last, app_cmd_en;
    logic [DW-1:0] rd_data, app_wdata;
    logic [2:0]    app_cmd;
    logic [AW-1:0] app_addr;
    logic [BW-1:0] app_burst_number;
    logic          app_wdata_en, app_wdata_end, busy, err_rd_unexp;
    logic [MW-1:0] app_wdata_mask;

    always #5 clk = ~clk;

    ddr3_app_sequencer dut (
        .clk(clk), .rstn(rstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data), .wd_mask(wd_mask),
        .rsp_free(rsp_free), .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last),
        .app_init_calib_complete(app_init_calib_complete), .app_cmd_ready(app_cmd_ready),
        .app_cmd(app_cmd), .app_cmd_en(app_cmd_en), .app_addr(app_addr),
        .app_burst_number(app_burst_number), .app_wdata_ready(app_wdata_ready),
        .app_wdata_en(app_wdata_en), .app_wdata_end(app_wdata_end), .app_wdata(app_wdata),
        .app_wdata_mask(app_wdata_mask), .app_rdata_valid(app_rdata_valid),
        .app_rdata_end(app_rdata_end), .app_rdata(app_rdata),
        .busy(busy), .err_rd_unexp(err_rd_unexp)
    );

    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Passive monitor of app-side and read-side traffic.
    int            en_cycles = 0, cmd_fires = 0, wr_cnt = 0, rd_cnt = 0, end_bad = 0;
    logic [2:0]    last_cmd = '0;
    logic [AW-1:0] last_addr = '0;
    logic [BW-1:0] last_bn = '0;
    logic [DW-1:0] wr_mem [0:63];
    logic [MW-1:0] wm_mem [0:63];
    logic [DW-1:0] rd_mem [0:63];
    logic          rdl_mem [0:63];

    always @(posedge clk) begin
        if (rstn) begin
            if (app_cmd_en) en_cycles <= en_cycles + 1;
            if (app_cmd_en && app_cmd_ready) begin
                cmd_fires <= cmd_fires + 1;
                last_cmd  <= app_cmd;
                last_addr <= app_addr;
                last_bn   <= app_burst_number;
            end
            if (app_wdata_en && app_wdata_ready) begin
                wr_mem[wr_cnt[5:0]] <= app_wdata;
                wm_mem[wr_cnt[5:0]] <= app_wdata_mask;
                if (!app_wdata_end) end_bad <= end_bad + 1;
                wr_cnt <= wr_cnt + 1;
            end
            if (rd_valid) begin
                rd_mem[rd_cnt[5:0]]  <= rd_data;
                rdl_mem[rd_cnt[5:0]] <= rd_last;
                rd_cnt <= rd_cnt + 1;
            end
        end
    end

    function automatic logic [DW-1:0] pat(input int i);
        return {32'(i), 32'hC0DE0000 | 32'(i), ~32'(i), 32'h5A5A5A5A};
    endfunction

    function automatic logic [DW-1:0] rpat(input int i);
        return {4{32'hBEEF0000 + 32'(i)}};
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic send_cmd(input logic wr, input logic [AW-1:0] addr, input logic [BW-1:0] len);
        logic acc;
        acc = 1'b0;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_len = len;
        for (int i = 0; i < 40 && !acc; i++) begin
            #1;
            acc = cmd_ready;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        check_eq("cmd_accept", acc, 1);
    endtask

    task automatic do_write(input logic [AW-1:0] addr, input logic [BW-1:0] len, input int hold,
                            input bit toggle, input int base, output int sent);
        logic fire;
        app_cmd_ready = (hold == 0);
        send_cmd(1'b1, addr, len);
        for (int i = 0; i < hold; i++) begin
            app_cmd_ready = 1'b0;
            tick();
        end
        app_cmd_ready = 1'b1;
        tick();
        sent = 0;
        for (int c = 0; c < 80 && sent <= int'(len); c++) begin
            wd_valid = 1'b1;
            wd_data  = pat(base + sent);
            wd_mask  = 16'(sent);
            app_wdata_ready = toggle ? (c % 2 == 0) : 1'b1;
            #1;
            fire = wd_ready;
            tick();
            if (fire) sent++;
        end
        wd_valid = 1'b0;
        app_wdata_ready = 1'b1;
    endtask

    task automatic return_beats(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            app_rdata_valid = 1'b1;
            app_rdata = rpat(base + i);
            tick();
        end
        app_rdata_valid = 1'b0;
        app_rdata = '0;
        tick();
        tick();
    endtask

    task automatic check_reset(input string tag);
        check_eq({tag, "_cmd_ready"}, cmd_ready, 0);
        check_eq({tag, "_wd_ready"}, wd_ready, 0);
        check_eq({tag, "_rd_valid"}, rd_valid, 0);
        check_eq({tag, "_rd_data"}, rd_data, 0);
        check_eq({tag, "_rd_last"}, rd_last, 0);
        check_eq({tag, "_app_cmd"}, app_cmd, 0);
        check_eq({tag, "_app_cmd_en"}, app_cmd_en, 0);
        check_eq({tag, "_app_addr"}, app_addr, 0);
        check_eq({tag, "_burst"}, app_burst_number, 0);
        check_eq({tag, "_wdata_en"}, app_wdata_en, 0);
        check_eq({tag, "_wdata_end"}, app_wdata_end, 0);
        check_eq({tag, "_wdata"}, app_wdata, 0);
        check_eq({tag, "_mask"}, app_wdata_mask, 16'hFFFF);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_err"}, err_rd_unexp, 0);
    endtask

    int e0, f0, w0, r0, sent, nl;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick();
        check_reset("rst");
        rstn = 1'b1;
        tick();
        tick();
        check_eq("cmd_ready_after_rst", cmd_ready, 1);

        // Write len=3 at 0x100, controller always ready.
        e0 = en_cycles; f0 = cmd_fires; w0 = wr_cnt;
        do_write(27'h100, 6'd3, 0, 1'b0, 0, sent);
        tick();
        check_eq("w1_en_cycles", en_cycles - e0, 1);
        check_eq("w1_fires", cmd_fires - f0, 1);
        check_eq("w1_cmd", last_cmd, 0);
        check_eq("w1_addr", last_addr, 27'h100);
        check_eq("w1_burst", last_bn, 3);
        check_eq("w1_sent", sent, 4);
        check_eq("w1_beats", wr_cnt - w0, 4);
        for (int k = 0; k < 4; k++) check_eq("w1_data", wr_mem[6'(w0 + k)], pat(k));
        check_eq("w1_mask", wm_mem[6'(w0 + 2)], 2);
        check_eq("w1_end", end_bad, 0);
        check_eq("w1_busy", busy, 0);

        // Write with command held off 5 cycles and data ready toggling.
        e0 = en_cycles; f0 = cmd_fires; w0 = wr_cnt;
        do_write(27'h2A0, 6'd3, 5, 1'b1, 16, sent);
        tick();
        check_eq("w2_en_cycles", en_cycles - e0, 6);
        check_eq("w2_fires", cmd_fires - f0, 1);
        check_eq("w2_beats", wr_cnt - w0, 4);
        for (int k = 0; k < 4; k++) check_eq("w2_data", wr_mem[6'(w0 + k)], pat(16 + k));
        check_eq("w2_end", end_bad, 0);
        check_eq("w2_busy", busy, 0);

        // Two reads back to back, len 7 then 1.
        rsp_free = 8'd16;
        e0 = en_cycles; f0 = cmd_fires; r0 = rd_cnt;
        send_cmd(1'b0, 27'h200, 6'd7);
        send_cmd(1'b0, 27'h300, 6'd1);
        tick();
        tick();
        check_eq("r2_fires", cmd_fires - f0, 2);
        check_eq("r2_no_stall", en_cycles - e0, 2);
        check_eq("r2_cmd", last_cmd, 1);
        check_eq("r2_addr", last_addr, 27'h300);
        check_eq("r2_burst", last_bn, 1);
        check_eq("r2_busy", busy, 1);
        return_beats(10, 100);
        check_eq("r2_beats", rd_cnt - r0, 10);
        for (int i = 0; i < 10; i++) check_eq("r2_last", rdl_mem[6'(r0 + i)], (i == 7 || i == 9));
        check_eq("r2_data0", rd_mem[6'(r0)], rpat(100));
        check_eq("r2_data9", rd_mem[6'(r0 + 9)], rpat(109));
        check_eq("r2_busy_end", busy, 0);

        // Credit gating: len=15 needs 16 free entries.
        rsp_free = 8'd8;
        e0 = en_cycles; f0 = cmd_fires; r0 = rd_cnt;
        send_cmd(1'b0, 27'h400, 6'd15);
        repeat (5) tick();
        check_eq("cr_hold", en_cycles - e0, 0);
        rsp_free = 8'd15;
        tick();
        check_eq("cr_15", app_cmd_en, 0);
        rsp_free = 8'd16;
        tick();
        check_eq("cr_16_en", app_cmd_en, 1);
        tick();
        check_eq("cr_fire", cmd_fires - f0, 1);
        return_beats(16, 200);
        check_eq("cr_beats", rd_cnt - r0, 16);
        nl = 0;
        for (int i = 0; i < 16; i++) if (rdl_mem[6'(r0 + i)]) nl++;
        check_eq("cr_last_cnt", nl, 1);
        check_eq("cr_last_pos", rdl_mem[6'(r0 + 15)], 1);

        // Outstanding limit: five single-beat reads, depth four.
        f0 = cmd_fires; r0 = rd_cnt;
        for (int i = 0; i < 5; i++) send_cmd(1'b0, 27'(32'h600 + i), 6'd0);
        repeat (4) tick();
        check_eq("oq_four", cmd_fires - f0, 4);
        check_eq("oq_hold_en", app_cmd_en, 0);
        check_eq("oq_busy", busy, 1);
        return_beats(1, 300);
        tick();
        check_eq("oq_fifth", cmd_fires - f0, 5);
        return_beats(4, 301);
        check_eq("oq_beats", rd_cnt - r0, 5);
        nl = 0;
        for (int i = 0; i < 5; i++) if (rdl_mem[6'(r0 + i)]) nl++;
        check_eq("oq_last_cnt", nl, 5);
        check_eq("oq_busy_end", busy, 0);

        // Unexpected read data while idle.
        check_eq("err_pre", err_rd_unexp, 0);
        app_rdata_valid = 1'b1;
        app_rdata = rpat(999);
        tick();
        app_rdata_valid = 1'b0;
        app_rdata = '0;
        check_eq("err_rd_valid", rd_valid, 1);
        check_eq("err_rd_last", rd_last, 0);
        check_eq("err_rd_data", rd_data, rpat(999));
        check_eq("err_set", err_rd_unexp, 1);
        tick();
        tick();
        check_eq("err_sticky", err_rd_unexp, 1);
        check_eq("err_rd_valid_off", rd_valid, 0);

        // Calibration loss blocks acceptance.
        app_init_calib_complete = 1'b0;
        #1;
        check_eq("calib_block", cmd_ready, 0);
        app_init_calib_complete = 1'b1;
        tick();
        check_eq("calib_back", cmd_ready, 1);

        // Reset in the middle of a write data phase.
        app_cmd_ready = 1'b1;
        send_cmd(1'b1, 27'h500, 6'd3);
        tick();
        wd_valid = 1'b1;
        app_wdata_ready = 1'b1;
        wd_data = pat(7);
        wd_mask = 16'h00F0;
        #1;
        check_eq("mid_wdata_en", app_wdata_en, 1);
        check_eq("mid_mask", app_wdata_mask, 16'h00F0);
        rstn = 1'b0;
        #1;
        check_reset("mid_rst");
        wd_valid = 1'b0;
        tick();
        rstn = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
